// File: rtl/ref_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ref_read_arbiter
// Purpose  : Round-robin arbiter that funnels NUM_REQ reference-reader burst
//            requests onto one DRAM read channel. It tracks up to OUTSTANDING
//            accepted bursts in an in-order tag FIFO and steers the returning
//            512-bit read data to the requester that owns the oldest burst.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            req_id/addr/len/valid_in  - per-requester burst requests
//            req_rdy_out               - one-hot request accept
//            req_data_out              - read data broadcast to all requesters
//            req_data_valid_out        - one-hot data valid (oldest burst owner)
//            req_data_rdy_in           - per-requester data accept
//            rd_id/addr/len_out, rd_info_valid_out, rd_info_rdy_in
//                                      - registered DRAM request channel
//            rd_data_in, rd_data_valid_in, rd_data_rdy_out
//                                      - DRAM read data channel
// Options  : REF_ARB_ID_TAG_EN - when defined, the top log2(NUM_REQ) bits of
//            rd_id_out carry the granted requester index.
// Revision : 1.0 - initial release
// ============================================================================
module ref_read_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6*NUM_REQ-1:0]  req_id_in,
    input  logic [32*NUM_REQ-1:0] req_addr_in,
    input  logic [8*NUM_REQ-1:0]  req_len_in,
    input  logic [NUM_REQ-1:0]    req_valid_in,
    output logic [NUM_REQ-1:0]    req_rdy_out,
    output logic [511:0]          req_data_out,
    output logic [NUM_REQ-1:0]    req_data_valid_out,
    input  logic [NUM_REQ-1:0]    req_data_rdy_in,
    output logic [5:0]            rd_id_out,
    output logic [31:0]           rd_addr_out,
    output logic [7:0]            rd_len_out,
    output logic                  rd_info_valid_out,
    input  logic                  rd_info_rdy_in,
    input  logic [511:0]          rd_data_in,
    input  logic                  rd_data_valid_in,
    output logic                  rd_data_rdy_out
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int c_CNT_W = $clog2(OUTSTANDING + 1);
    localparam int c_TAG_W = c_IDX_W + 8;
    localparam logic [c_CNT_W-1:0] c_MAX_OUT = c_CNT_W'(OUTSTANDING);
    localparam logic [NUM_REQ-1:0] c_ONE     = NUM_REQ'(1);

    // Per-requester views of the flattened request buses
    logic [5:0]  w_id   [NUM_REQ];
    logic [31:0] w_addr [NUM_REQ];
    logic [7:0]  w_len  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_id[i]   = req_id_in[6*i +: 6];
        assign w_addr[i] = req_addr_in[32*i +: 32];
        assign w_len[i]  = req_len_in[8*i +: 8];
    end

    logic [c_IDX_W-1:0] r_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [7:0]         r_beat_cnt;
    logic [c_TAG_W-1:0] r_fifo [OUTSTANDING];

    logic [c_IDX_W-1:0] w_grant;
    logic               w_load;
    logic [7:0]         w_len_sel;
    logic [7:0]         w_beats;
    logic [5:0]         w_id_next;
    logic               w_nonempty;
    logic [c_IDX_W-1:0] w_head_idx;
    logic [7:0]         w_head_beats;
    logic               w_beat;
    logic               w_pop;

    // Round-robin search: first valid requester at or after r_ptr, wrapping.
    // NUM_REQ is a power of two, so the index addition wraps naturally.
    always_comb begin
        logic               v_found;
        logic [c_IDX_W-1:0] v_cand;
        v_found = 1'b0;
        v_cand  = '0;
        w_grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_cand = r_ptr + c_IDX_W'(k);
            if (!v_found && req_valid_in[v_cand]) begin
                v_found = 1'b1;
                w_grant = v_cand;
            end
        end
    end

    assign w_load = (!rd_info_valid_out || rd_info_rdy_in) && (|req_valid_in)
                    && (r_count < c_MAX_OUT);
    assign req_rdy_out = w_load ? (c_ONE << w_grant) : '0;

    // Two 256-bit blocks per 512-bit beat; a zero length still costs one beat
    assign w_len_sel = w_len[w_grant];
    assign w_beats   = (w_len_sel == 8'd0) ? 8'd1
                       : 8'(({1'b0, w_len_sel} + 9'd1) >> 1);

`ifdef REF_ARB_ID_TAG_EN
    assign w_id_next = {w_grant, w_id[w_grant][5-c_IDX_W:0]};
`else
    assign w_id_next = w_id[w_grant];
`endif

    // DRAM request register: loads on grant, otherwise holds until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_info_valid_out <= 1'b0;
            rd_id_out         <= '0;
            rd_addr_out       <= '0;
            rd_len_out        <= '0;
            r_ptr             <= '0;
        end else if (w_load) begin
            rd_info_valid_out <= 1'b1;
            rd_id_out         <= w_id_next;
            rd_addr_out       <= w_addr[w_grant];
            rd_len_out        <= w_len_sel;
            r_ptr             <= w_grant + c_IDX_W'(1);
        end else if (rd_info_rdy_in) begin
            rd_info_valid_out <= 1'b0;
        end
    end

    // Tag FIFO storage; validity is tracked by the pointers and r_count
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_fifo[r_wr_ptr] <= {w_grant, w_beats};
        end
    end

    assign w_nonempty   = (r_count != '0);
    assign w_head_idx   = r_fifo[r_rd_ptr][c_TAG_W-1:8];
    assign w_head_beats = r_fifo[r_rd_ptr][7:0];

    // With nothing outstanding, DRAM data has no owner and is held off
    assign rd_data_rdy_out    = w_nonempty && req_data_rdy_in[w_head_idx];
    assign req_data_out       = w_nonempty ? rd_data_in : '0;
    assign req_data_valid_out = (w_nonempty && rd_data_valid_in) ? (c_ONE << w_head_idx) : '0;

    assign w_beat = rd_data_valid_in && rd_data_rdy_out;
    assign w_pop  = w_beat && (({1'b0, r_beat_cnt} + 9'd1) == {1'b0, w_head_beats});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (w_load) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_load && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_load && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if (w_pop) begin
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ref_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ref_read_arbiter
// Purpose  : Directed self-checking bench for ref_read_arbiter (NUM_REQ=4,
//            OUTSTANDING=8). Inputs change 1 time unit after the rising edge;
//            outputs are sampled 1 time unit later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ref_read_arbiter;

    logic          clk;
    logic          rst;
    logic [23:0]   req_id_in;
    logic [127:0]  req_addr_in;
    logic [31:0]   req_len_in;
    logic [3:0]    req_valid_in;
    logic [3:0]    req_rdy_out;
    logic [511:0]  req_data_out;
    logic [3:0]    req_data_valid_out;
    logic [3:0]    req_data_rdy_in;
    logic [5:0]    rd_id_out;
    logic [31:0]   rd_addr_out;
    logic [7:0]    rd_len_out;
    logic          rd_info_valid_out;
    logic          rd_info_rdy_in;
    logic [511:0]  rd_data_in;
    logic          rd_data_valid_in;
    logic          rd_data_rdy_out;

    int checks = 0;
    int errors = 0;

    ref_read_arbiter #(.NUM_REQ(4), .OUTSTANDING(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_id_in          (req_id_in),
        .req_addr_in        (req_addr_in),
        .req_len_in         (req_len_in),
        .req_valid_in       (req_valid_in),
        .req_rdy_out        (req_rdy_out),
        .req_data_out       (req_data_out),
        .req_data_valid_out (req_data_valid_out),
        .req_data_rdy_in    (req_data_rdy_in),
        .rd_id_out          (rd_id_out),
        .rd_addr_out        (rd_addr_out),
        .rd_len_out         (rd_len_out),
        .rd_info_valid_out  (rd_info_valid_out),
        .rd_info_rdy_in     (rd_info_rdy_in),
        .rd_data_in         (rd_data_in),
        .rd_data_valid_in   (rd_data_valid_in),
        .rd_data_rdy_out    (rd_data_rdy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        req_id_in        = '0;
        req_addr_in      = '0;
        req_len_in       = '0;
        req_valid_in     = '0;
        req_data_rdy_in  = '0;
        rd_info_rdy_in   = 1'b0;
        rd_data_in       = '0;
        rd_data_valid_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (rd_info_valid_out !== 1'b0) begin errors++; $display("FAIL reset_info_valid: got %b expected 0", rd_info_valid_out); end
        checks++; if (rd_addr_out !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", rd_addr_out); end
        checks++; if (rd_id_out !== 6'h0 || rd_len_out !== 8'h0) begin errors++; $display("FAIL reset_id_len: got %h/%h expected 0/0", rd_id_out, rd_len_out); end
        checks++; if (req_rdy_out !== 4'b0000) begin errors++; $display("FAIL reset_req_rdy: got %b expected 0000", req_rdy_out); end
        req_data_rdy_in  = 4'hF;
        rd_data_valid_in = 1'b1;
        rd_data_in       = {16{32'hCAFE_F00D}};
        #1;
        checks++; if (req_data_valid_out !== 4'b0000) begin errors++; $display("FAIL reset_data_valid: got %b expected 0000", req_data_valid_out); end
        checks++; if (rd_data_rdy_out !== 1'b0) begin errors++; $display("FAIL reset_data_rdy: got %b expected 0", rd_data_rdy_out); end
        checks++; if (req_data_out !== 512'h0) begin errors++; $display("FAIL reset_data_out: got %h expected 0", req_data_out[31:0]); end
        rd_data_valid_in = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_rdy;
        logic [31:0] exp_addr;
        do_reset();
        req_addr_in    = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        req_valid_in   = 4'hF;
        rd_info_rdy_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_rdy  = 4'b0001 << (k % 4);
            exp_addr = 32'h1000 * ((k % 4) + 1);
            #1;
            checks++; if (req_rdy_out !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_rdy_out, exp_rdy); end
            tick();
            checks++; if (rd_addr_out !== exp_addr || rd_info_valid_out !== 1'b1) begin errors++; $display("FAIL rr_addr%0d: got %h/%b expected %h/1", k, rd_addr_out, rd_info_valid_out, exp_addr); end
        end
        req_valid_in = '0;
    endtask

    task automatic test_hold();
        logic [511:0] exp_data;
        do_reset();
        req_addr_in[95:64] = 32'hA000_0000;
        req_len_in[23:16]  = 8'd5;
        req_valid_in       = 4'b0100;
        rd_info_rdy_in     = 1'b0;
        #1;
        checks++; if (req_rdy_out !== 4'b0100) begin errors++; $display("FAIL hold_grant: got %b expected 0100", req_rdy_out); end
        tick();
        req_valid_in = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (rd_info_valid_out !== 1'b1 || rd_addr_out !== 32'hA000_0000 || rd_len_out !== 8'd5) begin
                errors++; $display("FAIL hold_stable%0d: got v=%b a=%h l=%0d expected v=1 a=a0000000 l=5", c, rd_info_valid_out, rd_addr_out, rd_len_out); end
            checks++; if (req_rdy_out !== 4'b0000) begin errors++; $display("FAIL hold_no_grant%0d: got %b expected 0000", c, req_rdy_out); end
            if (c < 2) tick();
        end
        rd_info_rdy_in = 1'b1;
        req_valid_in   = '0;
        tick();
        rd_info_rdy_in = 1'b0;
        #1;
        checks++; if (rd_info_valid_out !== 1'b0) begin errors++; $display("FAIL hold_release: got %b expected 0", rd_info_valid_out); end
        req_data_rdy_in  = 4'hF;
        rd_data_valid_in = 1'b1;
        for (int b = 0; b < 3; b++) begin
            rd_data_in = {16{32'h0000_00D0 + b}};
            exp_data   = {16{32'h0000_00D0 + b}};
            #1;
            checks++; if (req_data_valid_out !== 4'b0100 || rd_data_rdy_out !== 1'b1) begin
                errors++; $display("FAIL hold_beat%0d: got dv=%b rdy=%b expected dv=0100 rdy=1", b, req_data_valid_out, rd_data_rdy_out); end
            checks++; if (req_data_out !== exp_data) begin errors++; $display("FAIL hold_data%0d: got %h expected %h", b, req_data_out[31:0], exp_data[31:0]); end
            tick();
        end
        #1;
        checks++; if (req_data_valid_out !== 4'b0000 || rd_data_rdy_out !== 1'b0) begin
            errors++; $display("FAIL hold_drained: got dv=%b rdy=%b expected dv=0000 rdy=0", req_data_valid_out, rd_data_rdy_out); end
        rd_data_valid_in = 1'b0;
    endtask

    task automatic test_outstanding();
        do_reset();
        req_len_in[7:0] = 8'd3;
        req_valid_in    = 4'b0001;
        rd_info_rdy_in  = 1'b1;
        req_data_rdy_in = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (req_rdy_out !== 4'b0001) begin errors++; $display("FAIL out_load%0d: got %b expected 0001", k, req_rdy_out); end
            tick();
        end
        #1;
        checks++; if (req_rdy_out !== 4'b0000) begin errors++; $display("FAIL out_full_a: got %b expected 0000", req_rdy_out); end
        tick();
        checks++; if (req_rdy_out !== 4'b0000) begin errors++; $display("FAIL out_full_b: got %b expected 0000", req_rdy_out); end
        rd_data_valid_in = 1'b1;
        #1;
        checks++; if (req_data_valid_out !== 4'b0001 || req_rdy_out !== 4'b0000) begin
            errors++; $display("FAIL out_beat1: got dv=%b rdy=%b expected dv=0001 rdy=0000", req_data_valid_out, req_rdy_out); end
        tick();
        checks++; if (req_rdy_out !== 4'b0000) begin errors++; $display("FAIL out_last_beat: got %b expected 0000", req_rdy_out); end
        tick();
        rd_data_valid_in = 1'b0;
        #1;
        checks++; if (req_rdy_out !== 4'b0001) begin errors++; $display("FAIL out_regrant: got %b expected 0001", req_rdy_out); end
        req_valid_in = '0;
    endtask

    task automatic test_in_order();
        do_reset();
        rd_info_rdy_in   = 1'b1;
        req_len_in[15:8] = 8'd2;
        req_valid_in     = 4'b0010;
        #1;
        checks++; if (req_rdy_out !== 4'b0010) begin errors++; $display("FAIL ord_grant1: got %b expected 0010", req_rdy_out); end
        tick();
        req_len_in[31:24] = 8'd4;
        req_valid_in      = 4'b1000;
        #1;
        checks++; if (req_rdy_out !== 4'b1000 || rd_len_out !== 8'd2) begin
            errors++; $display("FAIL ord_grant3: got rdy=%b len=%0d expected rdy=1000 len=2", req_rdy_out, rd_len_out); end
        tick();
        req_valid_in = '0;
        #1;
        checks++; if (rd_len_out !== 8'd4) begin errors++; $display("FAIL ord_len3: got %0d expected 4", rd_len_out); end
        req_data_rdy_in  = 4'hF;
        rd_data_valid_in = 1'b1;
        #1;
        checks++; if (req_data_valid_out !== 4'b0010) begin errors++; $display("FAIL ord_beat_r1: got %b expected 0010", req_data_valid_out); end
        tick();
        checks++; if (req_data_valid_out !== 4'b1000 || rd_data_rdy_out !== 1'b1) begin
            errors++; $display("FAIL ord_beat_r3a: got dv=%b rdy=%b expected dv=1000 rdy=1", req_data_valid_out, rd_data_rdy_out); end
        tick();
        req_data_rdy_in = 4'b0111;
        #1;
        checks++; if (rd_data_rdy_out !== 1'b0 || req_data_valid_out !== 4'b1000) begin
            errors++; $display("FAIL ord_stall: got rdy=%b dv=%b expected rdy=0 dv=1000", rd_data_rdy_out, req_data_valid_out); end
        tick();
        req_data_rdy_in = 4'hF;
        #1;
        checks++; if (req_data_valid_out !== 4'b1000 || rd_data_rdy_out !== 1'b1) begin
            errors++; $display("FAIL ord_beat_r3b: got dv=%b rdy=%b expected dv=1000 rdy=1", req_data_valid_out, rd_data_rdy_out); end
        tick();
        checks++; if (req_data_valid_out !== 4'b0000) begin errors++; $display("FAIL ord_drained: got %b expected 0000", req_data_valid_out); end
        rd_data_valid_in = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_addr_in[31:0] = 32'hBEEF_0000;
        req_len_in[7:0]   = 8'd7;
        req_valid_in      = 4'b0001;
        rd_info_rdy_in    = 1'b1;
        tick();
        req_valid_in = '0;
        tick();
        req_data_rdy_in  = 4'hF;
        rd_data_valid_in = 1'b1;
        rd_data_in       = {16{32'h1234_5678}};
        #1;
        checks++; if (req_data_valid_out !== 4'b0001) begin errors++; $display("FAIL mid_beat1: got %b expected 0001", req_data_valid_out); end
        tick();
        rd_data_valid_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (rd_info_valid_out !== 1'b0 || rd_addr_out !== 32'h0 || rd_len_out !== 8'h0) begin
            errors++; $display("FAIL mid_regs: got v=%b a=%h l=%0d expected all 0", rd_info_valid_out, rd_addr_out, rd_len_out); end
        rd_data_valid_in = 1'b1;
        #1;
        checks++; if (req_data_valid_out !== 4'b0000 || rd_data_rdy_out !== 1'b0 || req_data_out !== 512'h0) begin
            errors++; $display("FAIL mid_ignored: got dv=%b rdy=%b d=%h expected 0/0/0", req_data_valid_out, rd_data_rdy_out, req_data_out[31:0]); end
        tick();
        checks++; if (req_data_valid_out !== 4'b0000) begin errors++; $display("FAIL mid_ignored2: got %b expected 0000", req_data_valid_out); end
        rd_data_valid_in = 1'b0;
        req_valid_in     = 4'hF;
        #1;
        checks++; if (req_rdy_out !== 4'b0001) begin errors++; $display("FAIL mid_ptr: got %b expected 0001", req_rdy_out); end
        req_valid_in = '0;
    endtask

    task automatic test_id_tag();
        logic [5:0] exp_id;
`ifdef REF_ARB_ID_TAG_EN
        exp_id = 6'h35;
`else
        exp_id = 6'h05;
`endif
        do_reset();
        req_id_in[23:18] = 6'h05;
        req_valid_in     = 4'b1000;
        rd_info_rdy_in   = 1'b1;
        tick();
        req_valid_in = '0;
        #1;
        checks++; if (rd_id_out !== exp_id) begin errors++; $display("FAIL id_tag: got %h expected %h", rd_id_out, exp_id); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_hold();
        test_outstanding();
        test_in_order();
        test_reset_mid_burst();
        test_id_tag();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ref_read_arbiter.md
REF_READ_ARBITER -- requirements
Module: ref_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of reference-reader requesters (power of 2, 2..8).
REQ-002 SHALL have parameter OUTSTANDING, default 8, maximum accepted-but-uncompleted bursts (power of 2).
REQ-003 SHALL have port clk, input, 1, single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_id_in, input, 6*NUM_REQ, per-requester burst ID; slice i is [6i+5:6i].
REQ-006 SHALL have port req_addr_in, input, 32*NUM_REQ, per-requester burst address.
REQ-007 SHALL have port req_len_in, input, 8*NUM_REQ, per-requester burst length in 256-bit blocks.
REQ-008 SHALL have port req_valid_in, input, NUM_REQ, per-requester request valid.
REQ-009 SHALL have port req_rdy_out, output, NUM_REQ, per-requester request accepted (one-hot or zero).
REQ-010 SHALL have port req_data_out, output, 512, read data broadcast to all requesters.
REQ-011 SHALL have port req_data_valid_out, output, NUM_REQ, per-requester data valid (one-hot or zero).
REQ-012 SHALL have port req_data_rdy_in, input, NUM_REQ, per-requester data accepted.
REQ-013 SHALL have ports rd_id_out (6), rd_addr_out (32), rd_len_out (8), rd_info_valid_out (1), outputs: DRAM-side request.
REQ-014 SHALL have port rd_info_rdy_in, input, 1, DRAM-side request accepted.
REQ-015 SHALL have ports rd_data_in (512) and rd_data_valid_in (1), inputs, and rd_data_rdy_out (1), output: DRAM-side data.

Function
REQ-016 SHALL hold request outputs in a one-entry register; load when (!rd_info_valid_out || rd_info_rdy_in) && any req_valid_in && tracked count < OUTSTANDING.
REQ-017 SHALL select the requester on load by round-robin, starting from priority pointer ptr, lowest index after ptr wrapping to 0.
REQ-018 SHALL assert req_rdy_out[i] for exactly the load cycle of requester i, combinationally from the same conditions.
REQ-019 SHALL set ptr to (granted index + 1) mod NUM_REQ on each load; ptr unchanged otherwise.
REQ-020 SHALL hold rd_id_out/rd_addr_out/rd_len_out stable while rd_info_valid_out && !rd_info_rdy_in.
REQ-021 SHALL assert rd_info_valid_out the cycle after load (1-cycle latency); deassert after acceptance with no new load.
REQ-022 SHALL push {requester index, beats} into an in-order tag FIFO on each load; beats = ceil(len/2), len 0 treated as 1 beat.
REQ-023 SHALL count loaded-but-not-retired bursts; simultaneous push and pop leaves the count unchanged.
REQ-024 SHALL drive req_data_out = rd_data_in and req_data_valid_out[head] = rd_data_valid_in when tag FIFO non-empty; all zero when empty.
REQ-025 SHALL drive rd_data_rdy_out = FIFO non-empty && req_data_rdy_in[head]; 0 when empty (DRAM data held off).
REQ-026 SHALL count accepted data beats; on the beat equal to head's beats, pop the FIFO and clear the counter.

Reset
REQ-027 SHALL on rst clear rd_info_valid_out, ptr, tag FIFO, outstanding count and beat counter to 0; rd_id/addr/len_out to 0.
REQ-028 SHALL on rst mid-burst discard all tracking; data beats arriving after reset are not forwarded (FIFO empty).

Configuration
REQ-029 SHALL, when REF_ARB_ID_TAG_EN is defined, replace rd_id_out[5:6-log2(NUM_REQ)] with the granted requester index, lower bits from req_id_in.
REQ-030 SHALL, when REF_ARB_ID_TAG_EN is undefined, pass req_id_in of the granted requester to rd_id_out unmodified.

Verification
REQ-031 SHALL cover: all 4 requesters valid continuously, rd_info_rdy_in=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-032 SHALL cover: req 2 len=5 accepted, rd_info_rdy_in low 3 cycles -> rd_addr_out/len_out stable, valid held, then 3 data beats to req 2 only.
REQ-033 SHALL cover: 8 loads with no data returned -> 9th request not granted until first burst's last beat retires.
REQ-034 SHALL cover: req 1 len=2 then req 3 len=4 -> 1 beat to req 1, then 2 beats to req 3; req_data_rdy_in[3]=0 one cycle stalls rd_data_rdy_out.
REQ-035 SHALL cover: rst asserted after 1 of 4 beats -> all outputs 0 next cycle, subsequent rd_data_valid_in ignored.
REQ-036 SHALL cover: REF_ARB_ID_TAG_EN defined, req 3 id=6'h05 -> rd_id_out=6'h35; undefined -> 6'h05.
